// File: rtl/level_pkg.sv
// Shared types and constants for the tank level-sensor conditioning path.
package level_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } deb_state_t;

  localparam logic [1:0] P_NORMAL  = 2'b00;
  localparam logic [1:0] P_INCONS  = 2'b01;
  localparam logic [1:0] P_CHATTER = 2'b10;

  localparam int LVL_LOW  = 0;
  localparam int LVL_HIGH = 1;

endpackage

// File: rtl/level_debounce.sv
// One sensor channel: two-flop synchroniser followed by a STABLE/PENDING debounce FSM.
// abort pulses for one cycle when a pending change is abandoned.
module level_debounce
  import level_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic abort
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  // The sample that enters PENDING is the first of the required run, so
  // cnt tracks the additional samples and acceptance happens one short.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic [1:0]    sync_reg;
  logic          sync;
  deb_state_t    state_reg;
  logic [CW-1:0] cnt_reg;
  logic          level_reg;

  assign sync  = sync_reg[1];
  assign level = level_reg;
  assign abort = (state_reg == PENDING) && (sync == level_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg  <= '0;
      state_reg <= STABLE;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], raw};
      case (state_reg)
        STABLE: begin
          if (sync != level_reg) begin
            state_reg <= PENDING;
            cnt_reg   <= '0;
          end
        end
        PENDING: begin
          if (sync == level_reg) begin
            state_reg <= STABLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            level_reg <= sync;
            state_reg <= STABLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= STABLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/level_sensor_conditioner.sv
// Debounces both level sensors, detects chatter and implausible combinations,
// and produces the A level code and P fault code for the downstream level FSM.
module level_sensor_conditioner
  import level_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int INCONS_CYCLES   = 64,
  parameter int WINDOW_CYCLES   = 1024,
  parameter int CHATTER_MAX     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] raw_level,
  input  logic       fault_clr,
  output logic [1:0] A,
  output logic [1:0] P,
  output logic [1:0] chatter_ch
);

  localparam int WW = $clog2(WINDOW_CYCLES) + 1;
  localparam int AW = $clog2(CHATTER_MAX) + 1;
  localparam int IW = $clog2(INCONS_CYCLES) + 1;
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);
  localparam logic [AW-1:0] AB_MAX   = AW'(CHATTER_MAX);
  localparam logic [IW-1:0] INC_MAX  = IW'(INCONS_CYCLES);

  logic [1:0]    level_deb;
  logic [1:0]    abort;
  logic [1:0]    chat_cur;
  logic [1:0]    chat_next;
  logic [WW-1:0] win_cnt_reg;
  logic          win_wrap;
  logic [IW-1:0] incons_cnt_reg;
  logic [IW-1:0] incons_cnt_next;
  logic          incons_reg;
  logic          incons_next;
  logic          implausible;
  logic [1:0]    p_reg;
  logic [1:0]    p_next;

  assign win_wrap = (win_cnt_reg == WIN_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt_reg <= '0;
    end else begin
      win_cnt_reg <= win_wrap ? '0 : win_cnt_reg + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic [AW-1:0] ab_cnt_reg;
      logic [AW-1:0] ab_cnt_next;
      logic          chat_reg;
      logic          chat_nxt;

      level_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk  (clk),
        .reset(reset),
        .raw  (raw_level[gi]),
        .level(level_deb[gi]),
        .abort(abort[gi])
      );

      // An abort on the wrap edge is the first event of the new window.
      always_comb begin
        ab_cnt_next = ab_cnt_reg;
        if (win_wrap) begin
          ab_cnt_next = abort[gi] ? AW'(1) : '0;
        end else if (abort[gi] && (ab_cnt_reg != AB_MAX)) begin
          ab_cnt_next = ab_cnt_reg + 1'b1;
        end
        chat_nxt = chat_reg;
        if (fault_clr && (ab_cnt_reg < AB_MAX)) begin
          chat_nxt = 1'b0;
        end
        if (ab_cnt_next == AB_MAX) begin
          chat_nxt = 1'b1;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ab_cnt_reg <= '0;
          chat_reg   <= 1'b0;
        end else begin
          ab_cnt_reg <= ab_cnt_next;
          chat_reg   <= chat_nxt;
        end
      end

      assign chat_cur[gi]  = chat_reg;
      assign chat_next[gi] = chat_nxt;
    end
  endgenerate

  // High sensor wet while low sensor dry cannot happen in a real tank.
  assign implausible = level_deb[LVL_HIGH] && !level_deb[LVL_LOW];

  always_comb begin
    incons_cnt_next = '0;
    if (implausible) begin
      incons_cnt_next = (incons_cnt_reg == INC_MAX) ? incons_cnt_reg : incons_cnt_reg + 1'b1;
    end
    incons_next = incons_reg;
    if (fault_clr && !implausible) begin
      incons_next = 1'b0;
    end
    if (incons_cnt_next == INC_MAX) begin
      incons_next = 1'b1;
    end
  end

  always_comb begin
    p_next = P_NORMAL;
    if (incons_next) begin
      p_next = P_INCONS;
    end else if (|chat_next) begin
      p_next = P_CHATTER;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      incons_cnt_reg <= '0;
      incons_reg     <= 1'b0;
      p_reg          <= P_NORMAL;
    end else begin
      incons_cnt_reg <= incons_cnt_next;
      incons_reg     <= incons_next;
      p_reg          <= p_next;
    end
  end

  assign A          = level_deb;
  assign P          = p_reg;
  assign chatter_ch = chat_cur;

endmodule

// File: tb/tb_level_sensor_conditioner.sv
// Randomised and directed checks of level_sensor_conditioner against an
// edge-by-edge behavioural model built from run lengths and window indices.
module tb_level_sensor_conditioner;

  localparam int DEB = 4;
  localparam int INC = 8;
  localparam int WIN = 64;
  localparam int MAX = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] raw_level = 2'b00;
  logic       fault_clr = 1'b0;
  logic [1:0] A;
  logic [1:0] P;
  logic [1:0] chatter_ch;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         m_n;
  logic [1:0] m_a, m_s0, m_s1, m_chat, m_p;
  int         m_run [2];
  int         m_ab  [2];
  int         m_wid;
  int         m_ic;
  logic       m_incons;

  level_sensor_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .INCONS_CYCLES  (INC),
    .WINDOW_CYCLES  (WIN),
    .CHATTER_MAX    (MAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_level (raw_level),
    .fault_clr (fault_clr),
    .A         (A),
    .P         (P),
    .chatter_ch(chatter_ch)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_n = 0; m_a = 2'b00; m_s0 = 2'b00; m_s1 = 2'b00; m_chat = 2'b00; m_p = 2'b00;
    m_run[0] = 0; m_run[1] = 0; m_ab[0] = 0; m_ab[1] = 0;
    m_wid = 0; m_ic = 0; m_incons = 1'b0;
  endtask

  // A change is accepted after DEB consecutive differing synchronised samples;
  // a run broken early counts as one abort in the window the edge belongs to.
  task automatic model_edge();
    logic [1:0] a_pre;
    int         ab_pre [2];
    bit         ab [2];
    a_pre = m_a;
    m_n++;
    for (int ch = 0; ch < 2; ch++) begin
      ab[ch] = 1'b0;
      ab_pre[ch] = m_ab[ch];
      if (m_s1[ch] != a_pre[ch]) begin
        m_run[ch]++;
        if (m_run[ch] == DEB) begin
          m_a[ch] = m_s1[ch];
          m_run[ch] = 0;
        end
      end else begin
        ab[ch] = (m_run[ch] > 0);
        m_run[ch] = 0;
      end
    end
    if (m_n / WIN != m_wid) begin
      m_wid = m_n / WIN;
      m_ab[0] = 0;
      m_ab[1] = 0;
    end
    for (int ch = 0; ch < 2; ch++) begin
      if (ab[ch] && m_ab[ch] < MAX) m_ab[ch]++;
      if (fault_clr && ab_pre[ch] < MAX) m_chat[ch] = 1'b0;
      if (m_ab[ch] == MAX) m_chat[ch] = 1'b1;
    end
    if (a_pre == 2'b10) begin
      if (m_ic < INC) m_ic++;
    end else begin
      m_ic = 0;
    end
    if (fault_clr && a_pre != 2'b10) m_incons = 1'b0;
    if (m_ic == INC) m_incons = 1'b1;
    m_s1 = m_s0;
    m_s0 = raw_level;
    m_p = m_incons ? 2'b01 : (m_chat != 2'b00) ? 2'b10 : 2'b00;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (A !== 2'b00) begin bad++; $display("FAIL reset_A got=%b want=00", A); end
    total++;
    if (P !== 2'b00) begin bad++; $display("FAIL reset_P got=%b want=00", P); end
    total++;
    if (chatter_ch !== 2'b00) begin bad++; $display("FAIL reset_chatter got=%b want=00", chatter_ch); end
  endtask

  task automatic test_debounce();
    logic [1:0] exp_a;
    do_reset();
    raw_level = 2'b01;
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++;
      if ({A, P, chatter_ch} !== {m_a, m_p, m_chat}) begin
        bad++;
        $display("FAIL debounce_model edge=%0d got A=%b P=%b ch=%b want A=%b P=%b ch=%b",
                 k, A, P, chatter_ch, m_a, m_p, m_chat);
      end
      exp_a = (k >= DEB + 2) ? 2'b01 : 2'b00;
      total++;
      if (A !== exp_a || P !== 2'b00) begin
        bad++;
        $display("FAIL debounce_latency edge=%0d got A=%b P=%b want A=%b P=00", k, A, P, exp_a);
      end
    end
  endtask

  task automatic test_glitch();
    logic [1:0] exp_ch;
    do_reset();
    for (int g = 0; g < 3; g++) begin
      raw_level = 2'b01;
      for (int k = 0; k < 15; k++) begin
        if (k == 3) raw_level = 2'b00;
        tick();
        total++;
        if ({A, P, chatter_ch} !== {m_a, m_p, m_chat} || A !== 2'b00) begin
          bad++;
          $display("FAIL glitch_model n=%0d got A=%b P=%b ch=%b want A=00 P=%b ch=%b",
                   m_n, A, P, chatter_ch, m_p, m_chat);
        end
      end
      exp_ch = (g == 2) ? 2'b01 : 2'b00;
      total++;
      if (chatter_ch !== exp_ch) begin
        bad++;
        $display("FAIL glitch_abort_count glitch=%0d got ch=%b want ch=%b", g, chatter_ch, exp_ch);
      end
    end
  endtask

  task automatic test_incons();
    logic [1:0] exp_p;
    int         guard;
    do_reset();
    raw_level = 2'b10;
    guard = 0;
    do begin tick(); guard++; end while (A !== 2'b10 && guard < 20);
    total++;
    if (A !== 2'b10) begin bad++; $display("FAIL incons_reach_10 got A=%b want 10", A); end
    for (int k = 1; k <= INC + 2; k++) begin
      tick();
      exp_p = (k >= INC) ? 2'b01 : 2'b00;
      total++;
      if (P !== exp_p || P !== m_p) begin
        bad++;
        $display("FAIL incons_latency edge=%0d got P=%b want P=%b", k, P, exp_p);
      end
    end
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    total++;
    if (P !== 2'b01) begin bad++; $display("FAIL incons_clr_refused got P=%b want 01", P); end
    raw_level = 2'b11;
    guard = 0;
    do begin tick(); guard++; end while (A !== 2'b11 && guard < 20);
    total++;
    if (A !== 2'b11 || P !== 2'b01) begin
      bad++;
      $display("FAIL incons_to_11 got A=%b P=%b want A=11 P=01", A, P);
    end
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    total++;
    if (P !== 2'b00 || {A, P, chatter_ch} !== {m_a, m_p, m_chat}) begin
      bad++;
      $display("FAIL incons_clr got A=%b P=%b ch=%b want A=%b P=00 ch=%b", A, P, chatter_ch, m_a, m_chat);
    end
  endtask

  task automatic test_chatter();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      raw_level = (k % 4 < 2) ? 2'b10 : 2'b00;
      tick();
      total++;
      if ({A, P, chatter_ch} !== {m_a, m_p, m_chat}) begin
        bad++;
        $display("FAIL chatter_model n=%0d got A=%b P=%b ch=%b want A=%b P=%b ch=%b",
                 m_n, A, P, chatter_ch, m_a, m_p, m_chat);
      end
    end
    total++;
    if (chatter_ch !== 2'b10 || P !== 2'b10) begin
      bad++;
      $display("FAIL chatter_flag got ch=%b P=%b want ch=10 P=10", chatter_ch, P);
    end
    raw_level = 2'b10;
    for (int k = 0; k < 20; k++) tick();
    total++;
    if (P !== 2'b01 || chatter_ch !== 2'b10 || A !== 2'b10) begin
      bad++;
      $display("FAIL chatter_priority got A=%b P=%b ch=%b want A=10 P=01 ch=10", A, P, chatter_ch);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp_a;
    raw_level = 2'b00;
    for (int k = 0; k < 3; k++) tick();
    reset = 1'b1;
    #2;
    total++;
    if ({A, P, chatter_ch} !== 6'b0) begin
      bad++;
      $display("FAIL reset_mid_async got A=%b P=%b ch=%b want all 00", A, P, chatter_ch);
    end
    model_reset();
    @(posedge clk);
    #1;
    raw_level = 2'b01;
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_a = (k >= DEB + 2) ? 2'b01 : 2'b00;
      total++;
      if (A !== exp_a || P !== 2'b00 || A !== m_a) begin
        bad++;
        $display("FAIL reset_mid_relatency edge=%0d got A=%b P=%b want A=%b P=00", k, A, P, exp_a);
      end
    end
  endtask

  task automatic test_window();
    do_reset();
    while (m_n < 100) begin
      raw_level[0] = (m_n == 40 || m_n == 41 || m_n == 48 || m_n == 49 ||
                      m_n == 70 || m_n == 71 || m_n == 78 || m_n == 79);
      raw_level[1] = 1'b0;
      tick();
      total++;
      if ({A, P, chatter_ch} !== {m_a, m_p, m_chat}) begin
        bad++;
        $display("FAIL window_model n=%0d got A=%b P=%b ch=%b want A=%b P=%b ch=%b",
                 m_n, A, P, chatter_ch, m_a, m_p, m_chat);
      end
    end
    total++;
    if (chatter_ch !== 2'b00 || P !== 2'b00) begin
      bad++;
      $display("FAIL window_boundary got ch=%b P=%b want ch=00 P=00", chatter_ch, P);
    end
  endtask

  task automatic test_random();
    int hold;
    do_reset();
    for (int seg = 0; seg < 120; seg++) begin
      raw_level = 2'($urandom_range(0, 3));
      hold = ($urandom_range(0, 6) == 0) ? $urandom_range(20, 90) : $urandom_range(1, 8);
      for (int k = 0; k < hold; k++) begin
        fault_clr = ($urandom_range(0, 19) == 0);
        tick();
        total++;
        if ({A, P, chatter_ch} !== {m_a, m_p, m_chat}) begin
          bad++;
          $display("FAIL random_model n=%0d got A=%b P=%b ch=%b want A=%b P=%b ch=%b",
                   m_n, A, P, chatter_ch, m_a, m_p, m_chat);
        end
      end
    end
    fault_clr = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_debounce();
    test_glitch();
    test_incons();
    test_chatter();
    test_reset_mid();
    test_window();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
